axis_uart_tx_arbiter: RTL and testbench
=======================================

// Module: axis_uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmit path of the AXIS UART transceiver between N_REQ AXI-Stream
//  requesters. Round-robin arbitration at packet granularity: once granted, a requester owns
//  the TX path until its tlast beat is accepted. An optional header beat tags each packet with
//  the source index, and a stall timeout recovers from a requester that stalls mid-packet.
//  Sits between the requesters and the transceiver's s_axis_* slave port.
// PARAMETERS
//  AXI_DATA_WIDTH  32  beat width, matches transceiver s_axis_tdata
//  N_REQ           4   number of requesters, 2..16
//  HEADER_EN       1   1: emit one header beat {zeros, grant index} before each packet
//  TIMEOUT_CYCLES  1024 idle-valid cycles in STREAM before forced release; 0 disables
// PORTS
//  aclk           in   1                      clock
//  aresetn        in   1                      asynchronous reset, active low
//  s_axis_tdata   in   N_REQ*AXI_DATA_WIDTH   requester i data in slice [i*W +: W]
//  s_axis_tvalid  in   N_REQ                  per-requester valid
//  s_axis_tlast   in   N_REQ                  per-requester end of packet
//  s_axis_tready  out  N_REQ                  per-requester ready; at most one bit set
//  m_axis_tdata   out  AXI_DATA_WIDTH         to transceiver s_axis_tdata
//  m_axis_tvalid  out  1                      to transceiver s_axis_tvalid
//  m_axis_tready  in   1                      from transceiver s_axis_tready
//  m_axis_tid     out  ID_W                   current grant index, ID_W = max(1,$clog2(N_REQ))
//  busy           out  1                      1 while state != IDLE
//  timeout_err    out  1                      one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (aresetn=0, async): state=IDLE, m_axis_tvalid=0, s_axis_tready=0, m_axis_tid=0,
//   busy=0, timeout_err=0, last_grant=N_REQ-1 (requester 0 wins first), stall counter=0.
//  FSM IDLE -> HEADER|STREAM -> IDLE:
//   IDLE: m_axis_tvalid=0, all tready=0. If any s_axis_tvalid: grant = first valid index
//    searching last_grant+1 .. wrapping mod N_REQ; register grant; next HEADER if HEADER_EN
//    else STREAM. One-cycle arbitration latency; no beat is consumed in IDLE.
//   HEADER: m_axis_tvalid=1, m_axis_tdata = zero-extended grant; all s tready=0.
//    m_axis_tready=1 -> STREAM. Header is not subject to timeout.
//   STREAM: combinational pass-through of granted requester: m_axis_tdata/tvalid from slice
//    grant, s_axis_tready[grant]=m_axis_tready, other tready=0. Beat accepted when
//    tvalid&tready. Accepted beat with tlast -> IDLE, last_grant<=grant.
//  Timeout: in STREAM, counter increments each cycle s_axis_tvalid[grant]=0, clears on any
//   cycle with it 1. Counter reaching TIMEOUT_CYCLES-1 while still 0 -> IDLE next cycle,
//   timeout_err=1 for that one cycle, last_grant<=grant. TIMEOUT_CYCLES=0: never fires.
//   Backpressure (m_axis_tready=0 with valid=1) never counts toward timeout.
//  Grant is stable from IDLE exit until return to IDLE; requester tvalid changes of other
//   indices never affect the current packet. m_axis_tid valid whenever busy=1.
//  Single-beat packet (tlast on first beat): returns to IDLE, next grant after 1 idle cycle.
//  Wrap-around: last_grant=N_REQ-1 searches from 0. Only last_grant valid: it is re-granted.
//  AXIS rules: m_axis_tvalid, once high in HEADER, stays high with stable data until accepted.
//  Mid-packet reset: all state cleared immediately; partial packet is abandoned downstream.
// STRUCTURE
//  Package uart_arb_pkg: typedef enum {IDLE, HEADER, STREAM} arb_state_t; function
//   id_width(n) returning max(1,$clog2(n)).
//  Sub-module uart_rr_arbiter: combinational rotate-priority pick (req[N_REQ], last[ID_W]
//   -> gnt_idx, gnt_any); top holds FSM, registers, mux and timeout counter.
// TESTING
//  1 Reset: aresetn=0 mid-STREAM -> all outputs 0 same cycle, state IDLE, tready=0.
//  2 N_REQ=4, HEADER_EN=1: req0 and req2 valid, 3-beat packets -> header 0x0, 3 beats req0,
//    header 0x2, 3 beats req2; m_axis_tid 0 then 2; no beat interleaving.
//  3 All 4 valid, continuous 1-beat packets -> grant order 0,1,2,3,0 (wrap), none starved.
//  4 m_axis_tready held 0 for 50 cycles in STREAM, TIMEOUT_CYCLES=16 -> no timeout,
//    data/valid stable, packet completes after release.
//  5 req1 drops tvalid after beat 1 of 4, TIMEOUT_CYCLES=16 -> timeout_err one pulse at
//    16th stall cycle, busy=0 next cycle, next grant is req2 if valid.
//  6 HEADER_EN=0, req3 alone, 1-beat packet -> beat on m_axis one cycle after tvalid rise.

Source files
------------

// File: rtl/axis_uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX path arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2
  } arb_state_t;

  function automatic int id_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_uart_tx_arbiter_if.sv
// AXI-Stream bundle between N requesters, the arbiter and the UART transceiver.
interface axis_uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 32,
  parameter int ID_W  = id_width(N_REQ)
);
  logic [N_REQ*W-1:0] s_axis_tdata;
  logic [N_REQ-1:0]   s_axis_tvalid;
  logic [N_REQ-1:0]   s_axis_tlast;
  logic [N_REQ-1:0]   s_axis_tready;
  logic [W-1:0]       m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [ID_W-1:0]    m_axis_tid;

  // Arbiter view: consumes requester beats, drives the transceiver side.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid
  );

  // Environment view: requesters plus transceiver.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid
  );
endinterface

// File: rtl/axis_uart_tx_arbiter_rr.sv
// Combinational rotate-priority pick: first requester after 'last', wrapping mod N_REQ.
module uart_rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_any
);
  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest valid requester is written last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % N_REQ;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX stream among N_REQ AXIS requesters,
// with optional source-index header beat and mid-packet stall recovery.
module axis_uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int N_REQ          = 4,
  parameter int HEADER_EN      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_uart_tx_arbiter_if.slave  bus,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int W     = AXI_DATA_WIDTH;
  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             g_valid;
  logic             g_last;
  logic [W-1:0]     g_data;
  logic [W-1:0]     m_tdata;
  logic             m_tvalid;
  logic [N_REQ-1:0] s_tready;
  logic             to_fire;

  uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req     (bus.s_axis_tvalid),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign g_valid = bus.s_axis_tvalid[grant_q];
  assign g_last  = bus.s_axis_tlast[grant_q];
  assign g_data  = bus.s_axis_tdata[grant_q*W +: W];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    s_tready = '0;
    to_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = (HEADER_EN != 0) ? HEADER : STREAM;
        end
      end
      HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = W'(grant_q);
        if (bus.m_axis_tready) state_d = STREAM;
      end
      STREAM: begin
        m_tvalid          = g_valid;
        m_tdata           = g_data;
        s_tready[grant_q] = bus.m_axis_tready;
        // Only an absent requester counts as a stall; downstream backpressure never does.
        if (g_valid) begin
          cnt_d = '0;
          if (bus.m_axis_tready && g_last) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            to_fire = 1'b1;
            state_d = IDLE;
            last_d  = grant_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.m_axis_tdata  = m_tdata;
  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.s_axis_tready = s_tready;
  assign bus.m_axis_tid    = grant_q;
  assign busy              = (state_q != IDLE);
  assign timeout_err       = to_fire;
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Scoreboard bench: header-enabled and header-less arbiters share stimulus, one active at a time.
module tb_axis_uart_tx_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {logic [W-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [W-1:0] data; logic [IDW-1:0] tid;} exp_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic use_b = 1'b0;
  logic m_ready = 1'b1;
  logic [N*W-1:0] src_data = '0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_last = '0;

  beat_t srcq[N][$];
  exp_t  sb_q[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  logic           snap_mv, snap_to, snap_busy, snap_acc;
  logic [W-1:0]   snap_md;
  logic [IDW-1:0] snap_tid;

  logic rst_a_n, rst_b_n, busy_a, busy_b, to_a, to_b;
  assign rst_a_n = aresetn & ~use_b;
  assign rst_b_n = aresetn & use_b;

  axis_uart_tx_arbiter_if #(.N_REQ(N), .W(W), .ID_W(IDW)) bus_a ();
  axis_uart_tx_arbiter_if #(.N_REQ(N), .W(W), .ID_W(IDW)) bus_b ();

  axis_uart_tx_arbiter #(.AXI_DATA_WIDTH(W), .N_REQ(N), .HEADER_EN(1), .TIMEOUT_CYCLES(16)) dut_a (
    .aclk(clk), .aresetn(rst_a_n), .bus(bus_a.slave), .busy(busy_a), .timeout_err(to_a));
  axis_uart_tx_arbiter #(.AXI_DATA_WIDTH(W), .N_REQ(N), .HEADER_EN(0), .TIMEOUT_CYCLES(16)) dut_b (
    .aclk(clk), .aresetn(rst_b_n), .bus(bus_b.slave), .busy(busy_b), .timeout_err(to_b));

  assign bus_a.s_axis_tdata  = src_data;
  assign bus_a.s_axis_tvalid = src_valid;
  assign bus_a.s_axis_tlast  = src_last;
  assign bus_a.m_axis_tready = m_ready;
  assign bus_b.s_axis_tdata  = src_data;
  assign bus_b.s_axis_tvalid = src_valid;
  assign bus_b.s_axis_tlast  = src_last;
  assign bus_b.m_axis_tready = m_ready;

  logic [N-1:0]   sel_tready;
  logic           sel_mvalid, sel_to, sel_busy;
  logic [W-1:0]   sel_mdata;
  logic [IDW-1:0] sel_tid;
  assign sel_tready = use_b ? bus_b.s_axis_tready : bus_a.s_axis_tready;
  assign sel_mvalid = use_b ? bus_b.m_axis_tvalid : bus_a.m_axis_tvalid;
  assign sel_mdata  = use_b ? bus_b.m_axis_tdata  : bus_a.m_axis_tdata;
  assign sel_tid    = use_b ? bus_b.m_axis_tid    : bus_a.m_axis_tid;
  assign sel_to     = use_b ? to_b   : to_a;
  assign sel_busy   = use_b ? busy_b : busy_a;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_data(input int i, input int p, input int b);
    return 32'hD000_0000 | (32'(i) << 16) | (32'(p) << 8) | 32'(b);
  endfunction

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() != 0) begin
        src_valid[i]          = 1'b1;
        src_data[i*W +: W]    = srcq[i][0].data;
        src_last[i]           = srcq[i][0].last;
      end else begin
        src_valid[i]          = 1'b0;
        src_data[i*W +: W]    = '0;
        src_last[i]           = 1'b0;
      end
    end
  endtask

  // Queues a packet on requester i and the matching expected output (header first if hdr).
  task automatic load_pkt(input int i, input int p, input int n, input bit term, input bit hdr);
    beat_t b;
    exp_t  e;
    if (hdr) begin
      e.data = W'(i);
      e.tid  = IDW'(i);
      sb_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      b.data = mk_data(i, p, k);
      b.last = term && (k == n - 1);
      srcq[i].push_back(b);
      e.data = b.data;
      e.tid  = IDW'(i);
      sb_q.push_back(e);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) srcq[i].delete();
    sb_q.delete();
    acc_cnt = 0;
    drive_src();
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    exp_t e;
    @(negedge clk);
    acc       = src_valid & sel_tready;
    snap_mv   = sel_mvalid;
    snap_md   = sel_mdata;
    snap_tid  = sel_tid;
    snap_to   = sel_to;
    snap_busy = sel_busy;
    snap_acc  = sel_mvalid & m_ready;
    chk("onehot_tready", 32'($countones(sel_tready) <= 1), 1);
    if (snap_acc) begin
      $display("beat tid=%0d data=%h", snap_tid, snap_md);
      chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_data", snap_md, e.data);
        chk("sb_tid", 32'(snap_tid), 32'(e.tid));
      end
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) srcq[i].delete(0);
    drive_src();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, stall, to_at, pulses;
    bit started, chk_nb;

    // Reset state and mid-STREAM asynchronous reset
    do_reset();
    chk("rst_busy", sel_busy, 0);
    chk("rst_mvalid", sel_mvalid, 0);
    chk("rst_tready", sel_tready, 0);
    chk("rst_tid", sel_tid, 0);
    chk("rst_to", sel_to, 0);
    load_pkt(2, 0, 8, 1, 1);
    drive_src();
    n = 0;
    while (acc_cnt < 3 && n < 50) begin
      cycle();
      n++;
    end
    chk("t1_reach", acc_cnt, 3);
    chk("t1_busy_pre", sel_busy, 1);
    chk("t1_tid_pre", sel_tid, 2);
    #2 aresetn = 1'b0;
    #1;
    chk("t1_mvalid", sel_mvalid, 0);
    chk("t1_tready", sel_tready, 0);
    chk("t1_tid", sel_tid, 0);
    chk("t1_busy", sel_busy, 0);
    chk("t1_to", sel_to, 0);
    clear_all();
    @(posedge clk);
    #1 aresetn = 1'b1;
    cycle();
    cycle();
    chk("t1_idle_after", snap_busy, 0);

    // Two requesters, 3-beat packets, headers, no interleaving
    do_reset();
    load_pkt(0, 0, 3, 1, 1);
    load_pkt(2, 0, 3, 1, 1);
    drive_src();
    drain("t2_drain", 60);

    // All four valid with back-to-back single-beat packets: 0,1,2,3,0,1,2,3
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) load_pkt(i, p, 1, 1, 1);
    drive_src();
    drain("t3_drain", 100);

    // Downstream backpressure in STREAM for 50 cycles: no timeout, data held
    do_reset();
    load_pkt(0, 0, 3, 1, 1);
    drive_src();
    n = 0;
    while (acc_cnt < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("t4_reach", acc_cnt, 2);
    m_ready = 1'b0;
    repeat (50) begin
      cycle();
      chk("t4_mvalid", snap_mv, 1);
      chk("t4_mdata", snap_md, mk_data(0, 0, 1));
      chk("t4_to", snap_to, 0);
      chk("t4_busy", snap_busy, 1);
    end
    m_ready = 1'b1;
    drain("t4_drain", 20);

    // Requester 1 stalls after its first beat; requester 2 gets the path after recovery
    do_reset();
    load_pkt(1, 0, 1, 0, 1);
    load_pkt(2, 0, 2, 1, 1);
    drive_src();
    started = 0; chk_nb = 0; stall = 0; to_at = 0; pulses = 0; n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      cycle();
      n++;
      if (chk_nb) begin
        chk("t5_busy_after", snap_busy, 0);
        chk_nb = 0;
      end
      if (started) stall++;
      if (snap_to) begin
        pulses++;
        to_at = stall;
        chk_nb = 1;
      end
      if (snap_acc && snap_md == mk_data(1, 0, 0)) begin
        started = 1;
        stall = 0;
      end
    end
    chk("t5_drain", sb_q.size(), 0);
    chk("t5_pulses", pulses, 1);
    chk("t5_at_stall", to_at, 16);

    // Header-less variant: single beat appears one cycle after tvalid rises
    use_b = 1'b1;
    do_reset();
    load_pkt(3, 0, 1, 1, 0);
    drive_src();
    cycle();
    chk("t6_idle_mvalid", snap_mv, 0);
    cycle();
    chk("t6_lat_mvalid", snap_mv, 1);
    drain("t6_drain", 10);
    cycle();
    chk("t6_busy_end", snap_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
